// File: rtl/mul_seq.sv
// mul_seq: iterative 32x32 unsigned shift-add multiplier.
// One adder instance, one partial-product add per cycle.

module adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // 4-bit lookahead groups chained by group carry
  always_comb begin
    c    = '0;
    c[0] = c_i;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & p[4*k] & c[4*k]);
    end
  end

  assign s_o = p ^ c[31:0];
  assign c_o = c[32];

endmodule

module mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] P
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;

  logic [31:0] add_b;
  logic [31:0] sum;
  logic        c32;
  logic [63:0] shifted;

  assign add_b   = lo_q[0] ? mcand_q : 32'd0;
  assign shifted = {c32, sum, lo_q[31:1]};

  adder u_adder (
    .a_i (hi_q),
    .b_i (add_b),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (c32)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = A;
          lo_d    = B;
          hi_d    = 32'd0;
          cnt_d   = 6'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        hi_d  = shifted[63:32];
        lo_d  = shifted[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          p_d     = shifted;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors for mul_seq.
// Table-driven products plus multi-cycle corner sequences.

module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] P;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%h want 0x%h",
               nm, act, req);
    end
  endtask

  // One full transaction; hold = back-pressure cycles,
  // junk = drive a second operand pair while busy.
  task automatic do_op(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [63:0] exp,
                       input int hold,
                       input bit junk);
    int n;
    bit stable;
    @(negedge clk);
    chk(in_ready == 1'b1, "accept_ready",
        64'(in_ready), 64'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    if (junk) begin
      A = 32'hFFFF_FFFF;
      B = 32'hFFFF_FFFF;
    end else begin
      in_valid = 1'b0;
    end
    chk(in_ready == 1'b0, "busy_not_ready",
        64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (junk && n == 10)
        chk(in_ready == 1'b0, "junk_not_ready",
            64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    chk(n == 32, "latency", 64'(n), 64'd32);
    chk(P == exp, "product", P, exp);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!out_valid || P != exp) stable = 1'b0;
      end
      chk(stable, "hold_stable", P, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk(!out_valid && in_ready, "handshake_idle",
        {62'd0, out_valid, in_ready}, 64'd1);
    chk(P == exp, "product_kept", P, exp);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{32'd3, 32'd5, 64'hF};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0, 32'hFFFF_FFFF, 64'd0};
    vecs[3] = '{32'd1, 32'hDEAD_BEEF,
                64'h0000_0000_DEAD_BEEF};
    vecs[4] = '{32'hFFFF_FFFF, 32'd2,
                64'h0000_0001_FFFF_FFFE};

    #12;
    chk(P == 64'd0 && !out_valid && in_ready,
        "reset_state", P, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0);

    do_op(32'h1234_5678, 32'h9ABC_DEF0,
          64'h0B00_EA4E_242D_2080, 10, 1'b0);

    do_op(32'd7, 32'd6, 64'd42, 0, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk(!seen, "no_second_result",
        64'(seen), 64'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    A = 32'h8000_0000;
    B = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(!out_valid && in_ready && P == 64'd0,
        "async_reset", P, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk(!seen, "discarded_op",
        64'(seen), 64'd0);
    do_op(32'd2, 32'h8000_0000,
          64'h0000_0001_0000_0000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
